// File: rtl/reaction_round_controller.sv
// Round sequencer for the reaction-time game: arms the random-delay counter,
// lights "go", times the player's reaction with the score counter, and keeps
// the last round result plus the best (lowest) score since reset.
module reaction_round_controller #(
    parameter int                 SCORE_W  = 11,
    parameter logic [SCORE_W-1:0] NO_SCORE = '1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               React,
    input  logic               DelayDone,
    input  logic [SCORE_W-1:0] ScoreCount,
    input  logic               ScoreDone,
    output logic               DelayEnable,
    output logic               ScoreEnable,
    output logic               GoLed,
    output logic [SCORE_W-1:0] Score,
    output logic [SCORE_W-1:0] Best,
    output logic               FalseStart,
    output logic               Timeout,
    output logic [2:0]         State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_FALSE  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic start_q;
    logic react_q;
    logic start_edge;
    logic react_edge;
    logic delay_en_d;
    logic score_en_d;
    logic go_led_d;

    // Button history resets high so a button held through reset gives no edge.
    assign start_edge = Start & ~start_q;
    assign react_edge = React & ~react_q;

    assign State = state_q;

    // State register, button history and registered counter/LED controls.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b1;
            react_q     <= 1'b1;
            DelayEnable <= 1'b0;
            ScoreEnable <= 1'b0;
            GoLed       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= Start;
            react_q     <= React;
            DelayEnable <= delay_en_d;
            ScoreEnable <= score_en_d;
            GoLed       <= go_led_d;
        end
    end

    // Next-state selection; an early press beats DelayDone, a press beats ScoreDone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_ARM;
            end
            S_ARM: begin
                if (react_edge)     state_d = S_FALSE;
                else if (DelayDone) state_d = S_GO;
            end
            S_GO: begin
                if (react_edge || ScoreDone) state_d = S_RESULT;
            end
            S_RESULT, S_FALSE: begin
                if (start_edge) state_d = S_ARM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controls decoded from the next state so they track state entry and exit exactly.
    always_comb begin
        delay_en_d = (state_d == S_ARM);
        score_en_d = (state_d == S_GO);
        go_led_d   = (state_d == S_GO);
    end

    // Round result capture: score, best score and outcome flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Score      <= '0;
            Best       <= NO_SCORE;
            FalseStart <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            case (state_q)
                S_ARM: begin
                    if (react_edge) begin
                        FalseStart <= 1'b1;
                        Timeout    <= 1'b0;
                    end
                end
                S_GO: begin
                    if (react_edge) begin
                        Score      <= ScoreCount;
                        FalseStart <= 1'b0;
                        Timeout    <= 1'b0;
                        if (ScoreCount < Best) Best <= ScoreCount;
                    end else if (ScoreDone) begin
                        Score      <= NO_SCORE;
                        FalseStart <= 1'b0;
                        Timeout    <= 1'b1;
                    end
                end
                S_IDLE, S_RESULT, S_FALSE: begin
                    if (start_edge) begin
                        FalseStart <= 1'b0;
                        Timeout    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
